// File: rtl/dec_rr_arbiter.sv
// Eight-way round-robin arbiter. The winning index is decoded to a one-hot grant
// plus its active-low complement, with a dead cycle between owners and a hold timeout.
module dec_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [7:0] gnt_n,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // First set request at or after the pointer, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] sel;
        logic [2:0] k;
        sel = p;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (r[k]) begin
                sel = k;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    function automatic logic [7:0] dec3to8(input logic [2:0] a, input logic en);
        logic [7:0] y;
        if (en) begin
            y = 8'b0000_0001 << a;
        end else begin
            y = 8'h00;
        end
        return y;
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [2:0]       ptr_q,     ptr_d;
    logic [2:0]       idx_q,     idx_d;
    logic [CNT_W-1:0] hold_q,    hold_d;
    logic             timeout_q, timeout_d;
    logic             vld_q,     vld_d;
    logic [7:0]       gnt_q,     gnt_d;
    logic [7:0]       gnt_n_q,   gnt_n_d;

    // Next-state and grant bookkeeping; release wins over timeout on the same edge.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!en_n && (|req)) begin
                    idx_d   = rr_pick(req, ptr_q);
                    hold_d  = {CNT_W{1'b0}};
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (en_n || !req[idx_q]) begin
                    state_d = ST_GAP;
                    ptr_d   = idx_q + 3'd1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = ST_GAP;
                    ptr_d     = idx_q + 3'd1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d  = hold_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output images are computed from next state so every port comes straight off a flop.
    always_comb begin
        vld_d   = (state_d == ST_GRANT);
        gnt_d   = dec3to8(idx_d, vld_d);
        gnt_n_d = ~gnt_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            hold_q    <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
            vld_q     <= 1'b0;
            gnt_q     <= 8'h00;
            gnt_n_q   <= 8'hFF;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            vld_q     <= vld_d;
            gnt_q     <= gnt_d;
            gnt_n_q   <= gnt_n_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_n   = gnt_n_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign timeout = timeout_q;

    dec_rr_arbiter_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .gnt     (gnt),
        .gnt_n   (gnt_n),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

endmodule

// Output-consistency properties of the arbiter.
module dec_rr_arbiter_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [7:0] gnt,
    input logic [7:0] gnt_n,
    input logic       gnt_vld,
    input logic       timeout
);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_compl:  assert property (@(posedge clk) disable iff (!rst_n) gnt_n == ~gnt);
    a_vld:    assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == (|gnt));
    a_to_gap: assert property (@(posedge clk) disable iff (!rst_n) timeout |-> !gnt_vld);

endmodule
